// File: rtl/sobel_window_ctrl_if.sv
// Raster pixel-stream handshake between a pixel source (master) and sobel_window_ctrl (slave).
interface sobel_window_ctrl_if;
  logic [7:0] pix_in;
  logic       pix_valid;
  logic       pix_sof;
  logic       pix_ready;

  modport master (output pix_in, pix_valid, pix_sof, input pix_ready);
  modport slave  (input pix_in, pix_valid, pix_sof, output pix_ready);
endinterface

// File: rtl/sobel_window_ctrl.sv
// 3x3 window controller for sobel_core: two line buffers, border blanking and frame sequencing.
// Optional start-of-frame protocol checking is enabled by defining SOBEL_CTRL_ERR_EN.
module sobel_window_ctrl #(
  parameter int IMG_W = 256,
  parameter int IMG_H = 256
) (
  input  logic               clk,
  input  logic               rst,
  sobel_window_ctrl_if.slave pix,
  output logic [7:0]         Z1,
  output logic [7:0]         Z2,
  output logic [7:0]         Z3,
  output logic [7:0]         Z4,
  output logic [7:0]         Z5,
  output logic [7:0]         Z6,
  output logic [7:0]         Z7,
  output logic [7:0]         Z8,
  output logic [7:0]         Z9,
  output logic               valid_data,
  output logic               black_data,
  output logic               frame_done,
  output logic               err
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd2;
  localparam logic [2:0] S_FLUSH = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]           state;
  logic [CW-1:0]        in_col, out_col, wr_col;
  logic [RW-1:0]        in_row, out_row;
  logic [7:0]           lb0 [IMG_W];
  logic [7:0]           lb1 [IMG_W];
  logic [2:0][2:0][7:0] win, win_next, z_q;
  logic                 accept, sof_abort, emit, border, last_in, last_out;

  assign pix.pix_ready = !rst && (state == S_IDLE || state == S_LOAD || state == S_RUN);
  assign accept        = pix.pix_valid && pix.pix_ready;
  assign last_in       = (in_row == ROW_LAST) && (in_col == COL_LAST);
  assign last_out      = (out_row == ROW_LAST) && (out_col == COL_LAST);
  assign border        = (out_row == '0) || (out_row == ROW_LAST) ||
                         (out_col == '0) || (out_col == COL_LAST);
  assign emit          = ((state == S_RUN) && accept) || (state == S_FLUSH);

`ifdef SOBEL_CTRL_ERR_EN
  logic sof_missing;
  assign sof_abort   = accept && pix.pix_sof && (state != S_IDLE);
  assign sof_missing = accept && !pix.pix_sof && (state == S_IDLE);

  always_ff @(posedge clk) begin
    if (rst)                            err <= 1'b0;
    else if (sof_abort || sof_missing)  err <= 1'b1;
  end
`else
  logic unused_sof;
  assign unused_sof = pix.pix_sof;
  assign sof_abort  = 1'b0;
  assign err        = 1'b0;
`endif

  // A restarting pixel is pixel 0 of its frame, so it lands in column 0.
  assign wr_col = sof_abort ? '0 : in_col;

  always_comb begin
    // NOTE: assign a default to every always_comb output first so no path can infer a latch.
    win_next = win;
    for (int r = 0; r < 3; r++) begin
      win_next[r][0] = win[r][1];
      win_next[r][1] = win[r][2];
    end
    win_next[0][2] = lb1[wr_col];
    win_next[1][2] = lb0[wr_col];
    win_next[2][2] = pix.pix_in;
  end

  // NOTE: line buffers get no reset; stale lines only ever reach border windows, which are blanked.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb1[wr_col] <= lb0[wr_col];
      lb0[wr_col] <= pix.pix_in;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      in_col     <= '0;
      in_row     <= '0;
      out_col    <= '0;
      out_row    <= '0;
      win        <= '0;
      z_q        <= '0;
      valid_data <= 1'b0;
      black_data <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      valid_data <= 1'b0;
      black_data <= 1'b0;
      frame_done <= 1'b0;
      if (sof_abort) begin
        state   <= S_LOAD;
        win     <= win_next;
        in_col  <= CW'(1);
        in_row  <= '0;
        out_col <= '0;
        out_row <= '0;
      end else begin
        if (accept) begin
          win <= win_next;
          if (in_col == COL_LAST) begin
            in_col <= '0;
            in_row <= (in_row == ROW_LAST) ? '0 : in_row + 1'b1;
          end else begin
            in_col <= in_col + 1'b1;
          end
        end
        if (emit) begin
          valid_data <= !border;
          black_data <= border;
          z_q        <= border ? '0 : win_next;
          if (out_col == COL_LAST) begin
            out_col <= '0;
            out_row <= (out_row == ROW_LAST) ? '0 : out_row + 1'b1;
          end else begin
            out_col <= out_col + 1'b1;
          end
        end
        case (state)
          S_IDLE:  if (accept) state <= S_LOAD;
          // The window first reaches a complete centre once pixel IMG_W+1 arrives.
          S_LOAD:  if (accept && in_row == RW'(1) && in_col == '0) state <= S_RUN;
          S_RUN:   if (accept && last_in) state <= S_FLUSH;
          S_FLUSH: if (last_out) state <= S_DONE;
          S_DONE: begin
            frame_done <= 1'b1;
            in_col     <= '0;
            in_row     <= '0;
            out_col    <= '0;
            out_row    <= '0;
            state      <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign Z1 = z_q[0][0];
  assign Z2 = z_q[0][1];
  assign Z3 = z_q[0][2];
  assign Z4 = z_q[1][0];
  assign Z5 = z_q[1][1];
  assign Z6 = z_q[1][2];
  assign Z7 = z_q[2][0];
  assign Z8 = z_q[2][1];
  assign Z9 = z_q[2][2];
endmodule
